// File: rtl/branch_predict_ctrl_if.sv
// Fetch/execute-side signals of the branch predictor controller.
// The DUT connects via the slave modport; the fetch/execute pipeline drives the master side.
interface branch_predict_ctrl_if #(
  parameter int DBITS    = 32,
  parameter int CNT_BITS = 16
);
  logic [DBITS-1:0]    IF_PC;
  logic                IF_isBranch;
  logic [DBITS-1:0]    IF_target;
  logic                EX_valid;
  logic                EX_isBranch;
  logic [DBITS-1:0]    EX_PC;
  logic                EX_taken;
  logic [DBITS-1:0]    EX_target;
  logic                EX_predicted;
  logic                predict_taken;
  logic [DBITS-1:0]    pred_PC;
  logic                pc_override;
  logic [DBITS-1:0]    recover_PC;
  logic                flush;
  logic                stall;
  logic [CNT_BITS-1:0] branch_count;
  logic [CNT_BITS-1:0] mispredict_count;

  modport master (
    output IF_PC, IF_isBranch, IF_target, EX_valid, EX_isBranch, EX_PC,
           EX_taken, EX_target, EX_predicted,
    input  predict_taken, pred_PC, pc_override, recover_PC, flush, stall,
           branch_count, mispredict_count
  );

  modport slave (
    input  IF_PC, IF_isBranch, IF_target, EX_valid, EX_isBranch, EX_PC,
           EX_taken, EX_target, EX_predicted,
    output predict_taken, pred_PC, pc_override, recover_PC, flush, stall,
           branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_predict_ctrl.sv
// Bimodal branch predictor (2-bit counter BHT) with mispredict flush/recover
// sequencing and saturating resolution statistics.
//
// state   | meaning
// IDLE    | normal fetch; resolutions update BHT and may trigger recovery
// FLUSH   | one cycle: kill IF/ID, ID/EX and redirect fetch to recover_PC
// RECOVER | bubble cycles with fetch stalled; resolutions ignored
module branch_predict_ctrl #(
  parameter int DBITS          = 32,
  parameter int BHT_INDEX_BITS = 4,
  parameter int RECOVER_CYCLES = 2,
  parameter int CNT_BITS       = 16
) (
  input logic                  clk,
  input logic                  reset_n,
  branch_predict_ctrl_if.slave bus
);
  localparam int ENTRIES = 1 << BHT_INDEX_BITS;
  localparam int BW      = (RECOVER_CYCLES > 2) ? $clog2(RECOVER_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, FLUSH, RECOVER} state_t;

  state_t                    state;
  logic [1:0]                bht [ENTRIES];
  logic [BW-1:0]             bubble;
  logic [DBITS-1:0]          recover_pc;
  logic                      flush_r;
  logic                      override_r;
  logic                      stall_r;
  logic [CNT_BITS-1:0]       branch_cnt;
  logic [CNT_BITS-1:0]       mispred_cnt;
  logic [BHT_INDEX_BITS-1:0] if_idx;
  logic [BHT_INDEX_BITS-1:0] ex_idx;
  logic                      resolve;
  logic                      mispredict;

  assign if_idx     = bus.IF_PC[BHT_INDEX_BITS+1:2];
  assign ex_idx     = bus.EX_PC[BHT_INDEX_BITS+1:2];
  assign resolve    = bus.EX_valid & bus.EX_isBranch & (state == IDLE);
  assign mispredict = resolve & (bus.EX_taken != bus.EX_predicted);

  // Lookup reads the registered table, so a same-cycle update is not visible yet.
  assign bus.predict_taken    = bus.IF_isBranch & bht[if_idx][1];
  assign bus.pred_PC          = bus.predict_taken ? bus.IF_target : bus.IF_PC + DBITS'(4);
  assign bus.recover_PC       = recover_pc;
  assign bus.flush            = flush_r;
  assign bus.pc_override      = override_r;
  assign bus.stall            = stall_r;
  assign bus.branch_count     = branch_cnt;
  assign bus.mispredict_count = mispred_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) bht[i] <= 2'b01;
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (resolve) begin
        if (bus.EX_taken && bht[ex_idx] != 2'b11)
          bht[ex_idx] <= bht[ex_idx] + 2'd1;
        else if (!bus.EX_taken && bht[ex_idx] != 2'b00)
          bht[ex_idx] <= bht[ex_idx] - 2'd1;
        if (branch_cnt != '1) branch_cnt <= branch_cnt + CNT_BITS'(1);
      end
      if (mispredict && mispred_cnt != '1) mispred_cnt <= mispred_cnt + CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      bubble     <= '0;
      recover_pc <= '0;
      flush_r    <= 1'b0;
      override_r <= 1'b0;
      stall_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mispredict) begin
            state      <= FLUSH;
            flush_r    <= 1'b1;
            override_r <= 1'b1;
            stall_r    <= 1'b0;
            recover_pc <= bus.EX_taken ? bus.EX_target : bus.EX_PC + DBITS'(4);
          end
        end
        FLUSH: begin
          flush_r    <= 1'b0;
          override_r <= 1'b0;
          if (RECOVER_CYCLES == 0) begin
            state   <= IDLE;
            stall_r <= 1'b0;
          end else begin
            state   <= RECOVER;
            stall_r <= 1'b1;
            bubble  <= BW'(RECOVER_CYCLES - 1);
          end
        end
        RECOVER: begin
          if (bubble == '0) begin
            state   <= IDLE;
            stall_r <= 1'b0;
          end else begin
            bubble <= bubble - BW'(1);
          end
        end
        default: begin
          state      <= IDLE;
          flush_r    <= 1'b0;
          override_r <= 1'b0;
          stall_r    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/branch_predict_ctrl.md
BRANCH_PREDICT_CTRL -- requirements
Module: branch_predict_ctrl

Interface
REQ-001 Parameters (name, default, meaning):
- DBITS, 32, PC/target width.
- BHT_INDEX_BITS, 4, table index width (16 entries), index = PC[BHT_INDEX_BITS+1:2].
- RECOVER_CYCLES, 2, bubble cycles after a flush.
- CNT_BITS, 16, statistics counter width.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge.
- reset_n, in, 1, asynchronous active-low reset.
- IF_PC, in, DBITS, fetch-stage PC to predict.
- IF_isBranch, in, 1, fetched instruction is a branch (pre-decode).
- IF_target, in, DBITS, PC-relative target of fetched branch.
- EX_valid, in, 1, EX stage holds a live instruction.
- EX_isBranch, in, 1, EX instruction is a branch.
- EX_PC, in, DBITS, PC of EX branch.
- EX_taken, in, 1, actual outcome (condition flag).
- EX_target, in, DBITS, resolved target.
- EX_predicted, in, 1, prediction carried down the pipe for this branch.
- predict_taken, out, 1, prediction for IF_PC.
- pred_PC, out, DBITS, next fetch PC from prediction.
- pc_override, out, 1, force fetch to recover_PC.
- recover_PC, out, DBITS, corrected fetch PC.
- flush, out, 1, kill IF/ID and ID/EX contents.
- stall, out, 1, hold fetch during recovery.
- branch_count, out, CNT_BITS, resolved branches.
- mispredict_count, out, CNT_BITS, mispredicted branches.

Function
REQ-003 Branch history table: 2^BHT_INDEX_BITS entries of 2-bit saturating counters; states 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-004 predict_taken is combinational = IF_isBranch AND counter[idx(IF_PC)][1].
REQ-005 pred_PC = IF_target when predict_taken, else IF_PC+4 (modulo 2^DBITS, wrap-around ignored).
REQ-006 Resolution event = EX_valid AND EX_isBranch AND state==IDLE; events in any other state are ignored (instruction already flushed).
REQ-007 On resolution event, counter[idx(EX_PC)] increments if EX_taken, decrements otherwise, saturating at 11/00; written at the clock edge.
REQ-008 Same-cycle lookup and update of the same index: predict_taken uses the pre-update value.
REQ-009 Mispredict = resolution event AND (EX_taken != EX_predicted).
REQ-010 recover_PC = EX_target if EX_taken else EX_PC+4, captured in a register on the mispredict edge.
REQ-011 FSM states IDLE, FLUSH, RECOVER.
- IDLE -> FLUSH on mispredict; correct predictions stay IDLE.
- FLUSH: exactly 1 cycle; flush=1, pc_override=1, stall=0; -> RECOVER with bubble counter loaded to RECOVER_CYCLES-1.
- RECOVER: flush=0, pc_override=0, stall=1; counter decrements each cycle; -> IDLE on the cycle counter==0.
- RECOVER_CYCLES=0: FLUSH -> IDLE directly.
REQ-012 Mispredict latency: flush/pc_override assert the first cycle after the mispredicting edge (registered outputs).
REQ-013 branch_count increments per resolution event; mispredict_count per mispredict; both saturate at all-ones, never wrap.
REQ-014 In IDLE, flush=0, pc_override=0, stall=0.

Reset
REQ-015 reset_n low asynchronously forces: state IDLE, all BHT entries 01, bubble counter 0, recover_PC 0, both statistics counters 0, flush/pc_override/stall 0.
REQ-016 Reset asserted mid-FLUSH or mid-RECOVER aborts recovery immediately; outputs return to reset values in the same cycle, before the next edge.
REQ-017 Release of reset_n is synchronous to clk; the first resolution event may occur the first edge after release.

Verification
REQ-018 After reset, IF_PC=0x10, IF_isBranch=1, IF_target=0x40 -> predict_taken=0, pred_PC=0x14.
REQ-019 Resolve EX_PC=0x10, EX_taken=1, EX_predicted=0, EX_target=0x40 -> next cycle flush=1, pc_override=1, recover_PC=0x40; then 2 cycles stall=1; then IDLE; counter[4]=10, predict_taken=1 for IF_PC=0x10; branch_count=1, mispredict_count=1.
REQ-020 Resolve EX_PC=0x8, EX_taken=0, EX_predicted=0 -> no flush, counter[2]=00; repeat -> stays 00 (saturation).
REQ-021 During RECOVER, present a mispredicting resolution -> ignored: no new flush, counters and BHT unchanged.
REQ-022 Three taken resolutions on one index -> 01→10→11→11; a same-cycle lookup of that index sees the old value.
REQ-023 Assert reset_n=0 during FLUSH -> stall/flush/pc_override drop to 0 without a clock edge; BHT all 01; both counters 0.
